sram2_pair_reader: RTL and testbench

//  Read-side sequencer for the 1-write/2-read SRAM (simple_sram2). On start, fetches len operand pairs
//  (mem[base_a+i], mem[base_b+i]) through ports A/B and streams them out on a valid/ready interface.

---
 rtl/sram2_pair_reader_pkg.sv | 15 +
 rtl/sram2_pair_reader_pair_fifo.sv | 47 ++++
 rtl/sram2_pair_reader.sv | 143 ++++++++++++++
 tb/tb_sram2_pair_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram2_pair_reader_pkg.sv
// Shared types and default widths for the dual-read-port SRAM pair reader.
package sram2_pair_reader_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 11;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned LEN_WIDTH_DEF  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram2_pair_reader_pair_fifo.sv
// Two-entry FIFO with a registered head, so the read data leaves straight from a flop.
module sram2_pair_reader_pair_fifo #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             pop_ok;
    logic             push_ok;

    assign cnt     = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign cnt_nxt = cnt + 2'(push_ok) - 2'(pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            tail  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            empty <= (cnt_nxt == 2'd0);
            full  <= (cnt_nxt == 2'd2);
            if (pop_ok && full) begin
                dout <= tail;
            end else if (push_ok && (empty || pop_ok)) begin
                dout <= din;
            end
            if (push_ok && ((!empty && !pop_ok) || (full && pop_ok))) begin
                tail <= din;
            end
        end
    end

endmodule

// File: rtl/sram2_pair_reader.sv
// Fetches len operand pairs from a 1W/2R SRAM and streams them on a valid/ready interface.
module sram2_pair_reader
    import sram2_pair_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [ADDR_WIDTH-1:0] raddr_b,
    input  logic [DATA_WIDTH-1:0] dout_a,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  out_last
);

    state_t                  state, state_nxt;
    logic [LEN_WIDTH-1:0]    issue_cnt, issue_cnt_nxt;
    logic [LEN_WIDTH-1:0]    pop_cnt, pop_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   raddr_a_nxt, raddr_b_nxt;
    logic                    inflight, inflight_nxt;
    logic                    busy_nxt, done_nxt, out_valid_nxt, out_last_nxt;
    logic [1:0]              occ, occ_nxt;
    logic                    fire, credit_ok;
    logic                    fifo_full, fifo_empty;
    logic [2*DATA_WIDTH-1:0] fifo_dout;

    assign occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign fire = out_valid & out_ready;
    // Only issue when the read returning next cycle is guaranteed a FIFO slot.
    assign credit_ok = (3'(occ) + 3'(inflight)) < (3'd2 + 3'(fire));
    assign occ_nxt   = occ + 2'(inflight) - 2'(fire);
    assign out_a     = fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_b     = fifo_dout[DATA_WIDTH-1:0];

    sram2_pair_reader_pair_fifo #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_pair_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   ({dout_a, dout_b}),
        .pop   (fire),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt     = state;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        raddr_a_nxt   = raddr_a;
        raddr_b_nxt   = raddr_b;
        issue_cnt_nxt = issue_cnt;
        pop_cnt_nxt   = pop_cnt;
        inflight_nxt  = 1'b0;
        if (fire) begin
            pop_cnt_nxt = pop_cnt - LEN_WIDTH'(1);
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_nxt     = ST_RUN;
                        busy_nxt      = 1'b1;
                        raddr_a_nxt   = base_a;
                        raddr_b_nxt   = base_b;
                        issue_cnt_nxt = len;
                        pop_cnt_nxt   = len;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    inflight_nxt  = 1'b1;
                    raddr_a_nxt   = raddr_a + ADDR_WIDTH'(1);
                    raddr_b_nxt   = raddr_b + ADDR_WIDTH'(1);
                    issue_cnt_nxt = issue_cnt - LEN_WIDTH'(1);
                    if (issue_cnt == LEN_WIDTH'(1)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fire && out_last) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        out_valid_nxt = (occ_nxt != 2'd0);
        out_last_nxt  = out_valid_nxt && (pop_cnt_nxt == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            raddr_a   <= '0;
            raddr_b   <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            raddr_a   <= raddr_a_nxt;
            raddr_b   <= raddr_b_nxt;
            issue_cnt <= issue_cnt_nxt;
            pop_cnt   <= pop_cnt_nxt;
            inflight  <= inflight_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
        end
    end

endmodule

// File: tb/tb_sram2_pair_reader.sv
// Bench for sram2_pair_reader: behavioural 1-cycle-latency SRAM holding mem[i]=i*3 and a pair scoreboard.
module tb_sram2_pair_reader;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_a = '0;
    logic [AW-1:0] base_b = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done;
    logic [AW-1:0] raddr_a, raddr_b;
    logic [DW-1:0] dout_a = '0;
    logic [DW-1:0] dout_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_a, out_b;
    logic          out_last;

    sram2_pair_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // SRAM read ports: registered data, valid the cycle after the address
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        dout_a <= mem[raddr_a];
        dout_b <= mem[raddr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
    } pair_t;

    typedef struct {
        logic [AW-1:0] ba;
        logic [AW-1:0] bb;
        logic [LW-1:0] len;
        bit            rnd;
        int            inj;
        logic [DW-1:0] fa;
        logic [DW-1:0] la;
    } vec_t;

    pair_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Random backpressure, changed just after each rising edge
    bit rnd_mode = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on fire, stability check while stalled
    int            pop_idx = 0;
    logic [DW-1:0] first_a = '0;
    logic [DW-1:0] last_a = '0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] st_a = '0;
    logic [DW-1:0] st_b = '0;
    pair_t         mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_a", 64'(out_a), 64'(st_a));
                chk("stall_b", 64'(out_b), 64'(st_b));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pair_a", 64'(out_a), 64'(mon_e.a));
                    chk("pair_b", 64'(out_b), 64'(mon_e.b));
                    chk("pair_last", 64'(out_last), 64'(mon_e.last));
                    if (pop_idx == 0) first_a = out_a;
                    last_a = out_a;
                    pop_idx++;
                end
            end
            stall_q = out_valid && !out_ready;
            st_a    = out_a;
            st_b    = out_b;
        end
    end

    task automatic push_expected(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [LW-1:0] n);
        pair_t         e;
        logic [AW-1:0] aa, ab;
        for (int i = 0; i < int'(n); i++) begin
            aa     = AW'(int'(ba) + i);
            ab     = AW'(int'(bb) + i);
            e.a    = DW'(3 * int'(aa));
            e.b    = DW'(3 * int'(ab));
            e.last = (i == int'(n) - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_one(input vec_t v);
        logic [AW-1:0] ra0, rb0;
        int acc, fv, dl, dn;
        bit fin;
        rnd_mode = v.rnd;
        @(negedge clk);
        ra0 = raddr_a;
        rb0 = raddr_b;
        push_expected(v.ba, v.bb, v.len);
        pop_idx = 0;
        start  = 1'b1;
        base_a = v.ba;
        base_b = v.bb;
        len    = v.len;
        acc = cyc + 1;
        fv = -1; dl = -1; dn = 0; fin = 1'b0;
        for (int c = 0; c < 8 * int'(v.len) + 40 && !fin; c++) begin
            @(negedge clk);
            if (c == v.inj) begin
                start  = 1'b1;
                base_a = AW'(1000);
                base_b = AW'(1500);
                len    = LW'(3);
            end else begin
                start = 1'b0;
            end
            if (out_valid && fv < 0) fv = cyc - acc;
            if (done) begin
                dn++;
                if (dl < 0) dl = cyc - acc;
            end
            if (dl >= 0 && cyc - acc >= dl + 3) fin = 1'b1;
        end
        start = 1'b0;
        chk("run_complete", 64'(fin), 64'd1);
        chk("done_pulses", 64'(dn), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        if (v.len == '0) begin
            chk("len0_done_lat", 64'(dl), 64'd0);
            chk("len0_no_valid", 64'(fv), 64'(-1));
            chk("len0_raddr_a", 64'(raddr_a), 64'(ra0));
            chk("len0_raddr_b", 64'(raddr_b), 64'(rb0));
        end else begin
            chk("pop_count", 64'(pop_idx), 64'(v.len));
            chk("first_a", 64'(first_a), 64'(v.fa));
            chk("last_a", 64'(last_a), 64'(v.la));
            if (!v.rnd) begin
                chk("first_valid_lat", 64'(fv), 64'd2);
                chk("done_lat", 64'(dl), 64'(int'(v.len) + 2));
            end
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_raddr_a"}, 64'(raddr_a), 64'd0);
        chk({tag, "_raddr_b"}, 64'(raddr_b), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t post_rst;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 3);
        vecs[0] = '{ba: 11'd0,    bb: 11'd100,  len: 12'd4,    rnd: 1'b0, inj: -1, fa: 32'd0,    la: 32'd9};
        vecs[1] = '{ba: 11'd7,    bb: 11'd9,    len: 12'd0,    rnd: 1'b0, inj: -1, fa: 32'd0,    la: 32'd0};
        vecs[2] = '{ba: 11'd2046, bb: 11'd5,    len: 12'd4,    rnd: 1'b0, inj: -1, fa: 32'd6138, la: 32'd3};
        vecs[3] = '{ba: 11'd10,   bb: 11'd500,  len: 12'd8,    rnd: 1'b1, inj: -1, fa: 32'd30,   la: 32'd51};
        vecs[4] = '{ba: 11'd300,  bb: 11'd700,  len: 12'd6,    rnd: 1'b0, inj: 2,  fa: 32'd900,  la: 32'd915};
        vecs[5] = '{ba: 11'd2047, bb: 11'd2047, len: 12'd1,    rnd: 1'b0, inj: -1, fa: 32'd6141, la: 32'd6141};
        vecs[6] = '{ba: 11'd0,    bb: 11'd1024, len: 12'd2048, rnd: 1'b0, inj: -1, fa: 32'd0,    la: 32'd6141};
        vecs[7] = '{ba: 11'd100,  bb: 11'd200,  len: 12'd20,   rnd: 1'b1, inj: -1, fa: 32'd300,  la: 32'd357};
        post_rst = '{ba: 11'd50,  bb: 11'd60,   len: 12'd2,    rnd: 1'b0, inj: -1, fa: 32'd150,  la: 32'd153};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_one(vecs[i]);

        // Reset three cycles into a 16-pair run, then a fresh run
        rnd_mode = 1'b0;
        @(negedge clk);
        push_expected(11'd0, 11'd100, 12'd16);
        start  = 1'b1;
        base_a = 11'd0;
        base_b = 11'd100;
        len    = 12'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        repeat (2) @(negedge clk);
        check_reset_outputs("midrun_hold");
        exp_q.delete();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end
        run_one(post_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
